dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit between the single-cycle RISC-V core's execute stage and a handshaked 32-bit data memory. It takes one load or store request per transaction: byte, half or word size, signed or unsigned. It drives word-aligned memory beats with byte enables and returns the sign- or zero-extended load result. A misaligned access is split into two consecutive word beats, and the core stalls on `req_ready` while a transaction is in flight.

## Interface
- `XLEN`, default 32: data width; only 32 is supported.
- `AW`, default 32: address width; beat addresses wrap modulo 2^AW.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, 1: the core presents a request.
- `req_ready`, out, 1: high only in IDLE. A request is accepted when `req_valid` and `req_ready` are both high.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_size`, in, 2: `op_dmem_size` encoding: 00 byte, 01 half, 11 word; 10 is illegal.
- `req_unsigned`, in, 1: funct3[2]; selects zero-extension for LBU/LHU.
- `req_addr`, in, AW: byte address.
- `req_wdata`, in, XLEN: store data, right-aligned.
- `resp_valid`, out, 1: one-cycle pulse when the transaction completes. There is no backpressure on the response.
- `resp_rdata`, out, XLEN: extended load data; 0 for stores and errors.
- `resp_err`, out, 1: illegal size; qualified by `resp_valid`.
- `mem_req`, out, 1: beat request; held high until granted.
- `mem_gnt`, in, 1: the memory accepts the beat.
- `mem_we`, out, 1: beat is a write.
- `mem_addr`, out, AW: word-aligned beat address (bits [1:0] = 00).
- `mem_be`, out, 4: byte enables.
- `mem_wdata`, out, XLEN: lane-shifted store data.
- `mem_rvalid`, in, 1: beat completion. Exactly one per granted beat (read data or write ack), at least 1 cycle after `mem_gnt`.
- `mem_rdata`, in, XLEN: read data for the beat.

## Operation
- All inputs are captured at acceptance into registers: we, size, unsigned, addr, wdata. `off` = addr[1:0].
- Size mask `m`: byte 0001, half 0011, word 1111.
- The access is split when `off` + bytes > 4:
  - half at `off` = 3;
  - word at `off` = 1, 2 or 3.
- Beat 1:
  - `mem_addr` = {addr[AW-1:2], 00};
  - `mem_be` = (m << off)[3:0];
  - `mem_wdata` = (wdata << 8·off)[31:0].
- Beat 2 (split only):
  - `mem_addr` = beat-1 address + 4, wrapping; 0xFFFFFFFC + 4 = 0x00000000;
  - `mem_be` = (m << off)[7:4];
  - `mem_wdata` = wdata >> 8·(4−off).
- Load merge:
  - `r1` = beat-1 rdata; `r2` = beat-2 rdata, or 0 when not split.
  - `raw` = ({r2, r1} >> 8·off)[31:0].
  - Keep the low 8 or 16 bits of `raw` for byte/half, then sign- or zero-extend per `req_unsigned`. Words pass through unchanged.
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP.
- Transitions:
  - IDLE → REQ1 on accept; IDLE → RESP on accept with size 10 (`resp_err` = 1, no memory beat).
  - REQ1 → WAIT1 on `mem_gnt`.
  - WAIT1 → REQ2 on `mem_rvalid` when split, else → RESP. `r1` is latched.
  - REQ2 → WAIT2 on `mem_gnt`.
  - WAIT2 → RESP on `mem_rvalid`. `r2` is latched.
  - RESP → IDLE unconditionally.
- Outputs in each state:
  - `mem_req` = 1 only in REQ1/REQ2. `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` are stable while `mem_req` is high; they are 0 otherwise.
  - `resp_valid` = 1 only in RESP. `resp_rdata` and `resp_err` are held from RESP until the next RESP.
- `mem_rvalid` is ignored in any state other than WAIT1/WAIT2. `mem_gnt` is ignored outside REQ1/REQ2.

## Timing
- Reset values (next edge with `rst` = 1): state IDLE; `req_ready` = 1; `mem_req` = 0; `mem_be` = 0; `mem_addr` = 0; `mem_wdata` = 0; `mem_we` = 0; `resp_valid` = 0; `resp_err` = 0; `resp_rdata` = 0.
- Reset mid-transaction abandons the access. A late `mem_rvalid` from the abandoned beat is ignored because the unit is in IDLE.
- Latency, taking accept as cycle 0 with `mem_gnt` in the first REQ cycle and `mem_rvalid` 1 cycle after grant:
  - Aligned access: `mem_req` in cycle 1, `resp_valid` in cycle 3, `req_ready` again in cycle 4.
  - Split access: beats in cycles 1 and 3, `resp_valid` in cycle 5.
  - Illegal size: `resp_valid` with `resp_err` in cycle 1.
- Each cycle of `mem_gnt` or `mem_rvalid` delay adds one cycle to the latency.
- Back-to-back throughput: one aligned transaction per 4 cycles.

## Test plan
- **Aligned LW**, addr 0x100, `mem_rdata` 0xDEADBEEF, zero-wait memory → `mem_addr` 0x100, `mem_be` 1111; `resp_rdata` 0xDEADBEEF in cycle 3; `req_ready` high in cycle 4.
- **LB / LBU**, addr 0x103, `mem_rdata` 0x80123456 → `mem_be` 1000; LB → 0xFFFFFF80; LBU → 0x00000080.
- **SH**, addr 0x102, wdata 0x0000ABCD, `mem_gnt` delayed 2 cycles → `mem_req` held 3 cycles with `mem_be` 1100 and `mem_wdata` 0xABCD0000; `resp_rdata` 0.
- **Misaligned LW**, addr 0x201, r1 0x44332211, r2 0x88776655 → beat 1: 0x200, be 1110; beat 2: 0x204, be 0001; `resp_rdata` 0x55443322 in cycle 5.
- **Misaligned SW with wrap**, addr 0xFFFFFFFE, wdata 0x11223344 → beat 1: 0xFFFFFFFC, be 1100, wdata 0x33440000; beat 2: 0x00000000, be 0011, wdata 0x00001122.
- **Illegal size / reset**:
  - size 10 → `resp_valid` and `resp_err` in cycle 1, `mem_req` never high.
  - `rst` in WAIT1 → IDLE next cycle with `mem_req` 0; a subsequent stray `mem_rvalid` produces no `resp_valid`.

Source files
------------

// File: rtl/dmem_lsu.sv
// ---------------------------------------------------------------------------
// dmem_lsu
//   Load/store unit sitting between the execute stage of a single-cycle
//   RISC-V core and a handshaked 32-bit data memory. One load or store is
//   accepted per transaction (byte / half / word, signed or unsigned). It is
//   turned into one or two word-aligned memory beats with byte enables, and
//   the load result is returned sign- or zero-extended. An access that
//   crosses a word boundary is split into two consecutive beats. The core
//   stalls on req_ready while a transaction is in flight.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : core request handshake (ready only while idle)
//   req_we            : 1 = store, 0 = load
//   req_size          : 00 byte, 01 half, 11 word, 10 illegal
//   req_unsigned      : zero-extend byte/half loads
//   req_addr          : byte address
//   req_wdata         : right-aligned store data
//   resp_valid        : one-cycle completion pulse (no backpressure)
//   resp_rdata        : extended load data, 0 for stores and errors
//   resp_err          : illegal size, qualified by resp_valid
//   mem_req/gnt       : beat request, held until granted
//   mem_we            : beat is a write
//   mem_addr          : word-aligned beat address
//   mem_be            : beat byte enables
//   mem_wdata         : lane-shifted store data
//   mem_rvalid/rdata  : one completion per granted beat (data or write ack)
//   fsm_state         : current FSM state, for observation only
//
// Handshakes: a request transfers on a clock edge where req_valid and
// req_ready are both high; a memory beat transfers on an edge where mem_req
// and mem_gnt are both high, and mem_req with its address/enables/data stay
// stable until then; mem_rvalid is a single-cycle completion with no
// backpressure, as is resp_valid.
// ---------------------------------------------------------------------------
module dmem_lsu #(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [AW-1:0]   req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [2:0]      fsm_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ1  = 3'd1;
    localparam logic [2:0] S_WAIT1 = 3'd2;
    localparam logic [2:0] S_REQ2  = 3'd3;
    localparam logic [2:0] S_WAIT2 = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_BAD = 2'b10;
    localparam logic [1:0] SIZE_W   = 2'b11;

    logic [2:0]      state_q;
    logic [2:0]      state_d;

    // Request captured at acceptance
    logic            we_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [AW-1:0]   addr_q;
    logic [XLEN-1:0] wdata_q;

    // First-beat read data, kept while the second beat is outstanding
    logic [XLEN-1:0] r1_q;

    logic [XLEN-1:0] resp_rdata_q;
    logic            resp_err_q;

    logic [1:0]        off;
    logic [3:0]        size_mask;
    logic [7:0]        be_wide;
    logic [2*XLEN-1:0] wdata_wide;
    logic              split;
    logic [AW-1:0]     base_addr;
    logic [AW-1:0]     next_addr;

    logic [XLEN-1:0] merge_r1;
    logic [XLEN-1:0] merge_r2;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] load_result;
    logic [XLEN-1:0] done_rdata;

    // ------------------------------------------------------------------
    // Beat geometry, all derived from the captured request
    // ------------------------------------------------------------------
    assign off = addr_q[1:0];

    always_comb begin
        size_mask = 4'b0000;
        case (size_q)
            SIZE_B:  size_mask = 4'b0001;
            SIZE_H:  size_mask = 4'b0011;
            SIZE_W:  size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    end

    // Enables and data are laid out across an 8-byte window; the low half
    // belongs to beat 1 and whatever spills into the high half to beat 2.
    assign be_wide    = {4'b0000, size_mask} << off;
    assign wdata_wide = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};

    // Any enable landing past lane 3 means the access crosses a word.
    assign split = |be_wide[7:4];

    assign base_addr = {addr_q[AW-1:2], 2'b00};
    // Plain AW-bit addition, so the last word of the space wraps to zero.
    assign next_addr = base_addr + {{(AW-3){1'b0}}, 3'd4};

    // ------------------------------------------------------------------
    // Memory-side outputs: driven only while a beat is requested
    // ------------------------------------------------------------------
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0000;
        mem_wdata = '0;
        case (state_q)
            S_REQ1: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = base_addr;
                mem_be    = be_wide[3:0];
                mem_wdata = wdata_wide[XLEN-1:0];
            end
            S_REQ2: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = next_addr;
                mem_be    = be_wide[7:4];
                mem_wdata = wdata_wide[2*XLEN-1:XLEN];
            end
            default: begin
                mem_req   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load merge. The result is formed in the cycle the last beat returns,
    // straight from mem_rdata, so no extra cycle is spent on alignment.
    // ------------------------------------------------------------------
    always_comb begin
        merge_r1 = mem_rdata;
        merge_r2 = '0;
        if (state_q == S_WAIT2) begin
            merge_r1 = r1_q;
            merge_r2 = mem_rdata;
        end
    end

    assign raw = XLEN'({merge_r2, merge_r1} >> {off, 3'b000});

    always_comb begin
        load_result = raw;
        case (size_q)
            SIZE_B:  load_result = {{(XLEN-8){~uns_q & raw[7]}}, raw[7:0]};
            SIZE_H:  load_result = {{(XLEN-16){~uns_q & raw[15]}}, raw[15:0]};
            default: load_result = raw;
        endcase
    end

    assign done_rdata = we_q ? '0 : load_result;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = (req_size == SIZE_BAD) ? S_RESP : S_REQ1;
                end
            end
            S_REQ1: begin
                if (mem_gnt) state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (mem_rvalid) state_d = split ? S_REQ2 : S_RESP;
            end
            S_REQ2: begin
                if (mem_gnt) state_d = S_WAIT2;
            end
            S_WAIT2: begin
                if (mem_rvalid) state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= SIZE_B;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            r1_q         <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == S_IDLE && req_valid) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                // An illegal size completes without touching memory, so its
                // response is fixed right here.
                if (req_size == SIZE_BAD) begin
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b1;
                end
            end

            if (state_q == S_WAIT1 && mem_rvalid) begin
                r1_q <= mem_rdata;
                if (!split) begin
                    resp_rdata_q <= done_rdata;
                    resp_err_q   <= 1'b0;
                end
            end

            if (state_q == S_WAIT2 && mem_rvalid) begin
                resp_rdata_q <= done_rdata;
                resp_err_q   <= 1'b0;
            end
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// ---------------------------------------------------------------------------
// tb_dmem_lsu
//   Bench for dmem_lsu: reset check, a table of directed load/store vectors,
//   a reset-in-flight / stray-completion sequence, and randomized
//   transactions checked against a byte-addressed reference memory.
// ---------------------------------------------------------------------------
module tb_dmem_lsu;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [2:0]  fsm_state;

    dmem_lsu #(.XLEN(32), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .fsm_state(fsm_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters and compare helper
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;
    int n_resp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory responder (word storage, byte-enable writes) and beat log
    // ------------------------------------------------------------------
    logic [31:0] mem_words [logic [31:0]];
    int  gnt_delay = 0;
    int  rv_delay  = 0;
    bit  mem_auto  = 1'b1;
    int  mst  = 0;
    int  wcnt = 0;
    logic [31:0] pend_addr;
    logic        pend_we;

    logic [31:0] b_addr_q[$];
    logic [31:0] b_wdata_q[$];
    logic [3:0]  b_be_q[$];
    logic        b_we_q[$];
    int          b_hold_q[$];

    function automatic logic [31:0] dflt_word(input logic [31:0] wa);
        return wa ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] wa);
        if (mem_words.exists(wa)) return mem_words[wa];
        return dflt_word(wa);
    endfunction

    always @(negedge clk) begin
        if (mem_auto) begin
            logic [31:0] w;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (rst) begin
                mst  = 0;
                wcnt = 0;
            end else if (mst == 0) begin
                if (mem_req) begin
                    if (wcnt == gnt_delay) begin
                        mem_gnt = 1'b1;
                        b_addr_q.push_back(mem_addr);
                        b_wdata_q.push_back(mem_wdata);
                        b_be_q.push_back(mem_be);
                        b_we_q.push_back(mem_we);
                        b_hold_q.push_back(wcnt + 1);
                        pend_addr = mem_addr;
                        pend_we   = mem_we;
                        if (mem_we) begin
                            w = rd_word(mem_addr);
                            for (int i = 0; i < 4; i++)
                                if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                            mem_words[mem_addr] = w;
                        end
                        mst  = 1;
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end
            end else begin
                if (wcnt == rv_delay) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_we ? 32'h0BAD_0BAD : rd_word(pend_addr);
                    mst  = 0;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Response pulse counter and idle-bus watcher
    always @(negedge clk) begin
        if (resp_valid) n_resp++;
        if (!rst && !mem_req)
            check("idle_bus_zero", mem_addr | mem_wdata | {27'd0, mem_be, mem_we}, 32'd0);
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic clear_beats();
        b_addr_q.delete(); b_wdata_q.delete(); b_be_q.delete();
        b_we_q.delete(); b_hold_q.delete();
    endtask

    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, output int acc);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!req_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            n_vec++; n_err++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic [31:0] rd, output logic er, output int rc);
        int n;
        n = 0;
        while (!resp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        rd = resp_rdata; er = resp_err; rc = cyc;
        if (!resp_valid) begin
            n_vec++; n_err++;
            $display("FAIL resp_timeout: got no resp_valid expected a pulse");
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word0;
        logic [31:0] word1;
        int          gd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_beats;
        int          exp_lat;
        int          exp_hold;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] a2;
        logic [3:0]  be2;
        logic [31:0] wd2;
    } vec_t;

    localparam int NV = 12;
    vec_t vt [NV];

    task automatic fill_table();
        //          we  size   uns  addr           wdata          word0          word1          gd rdata          err beats lat hold a1            be1      wd1            a2            be2      wd2
        vt[0]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 32'h0,         0, 32'hDEAD_BEEF, 1'b0, 1, 3, 1, 32'h0000_0100, 4'b1111, 32'h0,         32'h0,         4'b0000, 32'h0};
        vt[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,         32'h8012_3456, 32'h0,         0, 32'hFFFF_FF80, 1'b0, 1, 3, 1, 32'h0000_0100, 4'b1000, 32'h0,         32'h0,         4'b0000, 32'h0};
        vt[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,         32'h8012_3456, 32'h0,         0, 32'h0000_0080, 1'b0, 1, 3, 1, 32'h0000_0100, 4'b1000, 32'h0,         32'h0,         4'b0000, 32'h0};
        vt[3]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_ABCD, 32'h0,         32'h0,         2, 32'h0,         1'b0, 1, 5, 3, 32'h0000_0100, 4'b1100, 32'hABCD_0000, 32'h0,         4'b0000, 32'h0};
        vt[4]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0201, 32'h0,         32'h4433_2211, 32'h8877_6655, 0, 32'h5544_3322, 1'b0, 2, 5, 1, 32'h0000_0200, 4'b1110, 32'h0,         32'h0000_0204, 4'b0001, 32'h0};
        vt[5]  = '{1'b1, 2'b11, 1'b0, 32'hFFFF_FFFE, 32'h1122_3344, 32'h0,         32'h0,         0, 32'h0,         1'b0, 2, 5, 1, 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000, 32'h0000_0000, 4'b0011, 32'h0000_1122};
        vt[6]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0,         32'h0,         32'h0,         0, 32'h0,         1'b1, 0, 1, 0, 32'h0,         4'b0000, 32'h0,         32'h0,         4'b0000, 32'h0};
        vt[7]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0103, 32'h0,         32'h8012_3456, 32'h0000_00FF, 0, 32'hFFFF_FF80, 1'b0, 2, 5, 1, 32'h0000_0100, 4'b1000, 32'h0,         32'h0000_0104, 4'b0001, 32'h0};
        vt[8]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,         32'h8012_3456, 32'h0,         0, 32'h0000_8012, 1'b0, 1, 3, 1, 32'h0000_0100, 4'b1100, 32'h0,         32'h0,         4'b0000, 32'h0};
        vt[9]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00AB, 32'h0,         32'h0,         0, 32'h0,         1'b0, 1, 3, 1, 32'h0000_0100, 4'b0010, 32'h0000_AB00, 32'h0,         4'b0000, 32'h0};
        vt[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_F00D, 32'h0,         0, 32'hFFFF_F00D, 1'b0, 1, 3, 1, 32'h0000_0100, 4'b0011, 32'h0,         32'h0,         4'b0000, 32'h0};
        vt[11] = '{1'b1, 2'b11, 1'b0, 32'h0000_0400, 32'hCAFE_BABE, 32'h0,         32'h0,         1, 32'h0,         1'b0, 1, 4, 2, 32'h0000_0400, 4'b1111, 32'hCAFE_BABE, 32'h0,         4'b0000, 32'h0};
    endtask

    task automatic run_directed();
        vec_t v;
        int acc, rc;
        logic [31:0] rd;
        logic er;
        logic [31:0] wa;
        for (int i = 0; i < NV; i++) begin
            v = vt[i];
            gnt_delay = v.gd;
            rv_delay  = 0;
            wa = {v.addr[31:2], 2'b00};
            mem_words[wa] = v.word0;
            mem_words[wa + 32'd4] = v.word1;
            clear_beats();
            send(v.we, v.size, v.uns, v.addr, v.wdata, acc);
            wait_resp(rd, er, rc);
            check($sformatf("v%0d_latency", i), rc - acc, v.exp_lat);
            check($sformatf("v%0d_rdata", i), rd, v.exp_rdata);
            check($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, v.exp_err});
            check($sformatf("v%0d_beats", i), b_addr_q.size(), v.exp_beats);
            if (b_addr_q.size() >= 1) begin
                check($sformatf("v%0d_b1_addr", i), b_addr_q[0], v.a1);
                check($sformatf("v%0d_b1_be", i), {28'd0, b_be_q[0]}, {28'd0, v.be1});
                check($sformatf("v%0d_b1_we", i), {31'd0, b_we_q[0]}, {31'd0, v.we});
                check($sformatf("v%0d_b1_hold", i), b_hold_q[0], v.exp_hold);
                if (v.we) check($sformatf("v%0d_b1_wdata", i), b_wdata_q[0], v.wd1);
            end
            if (b_addr_q.size() >= 2) begin
                check($sformatf("v%0d_b2_addr", i), b_addr_q[1], v.a2);
                check($sformatf("v%0d_b2_be", i), {28'd0, b_be_q[1]}, {28'd0, v.be2});
                if (v.we) check($sformatf("v%0d_b2_wdata", i), b_wdata_q[1], v.wd2);
            end
            // Cycle after the response: back to idle, result still held
            @(negedge clk);
            check($sformatf("v%0d_ready_after", i), {31'd0, req_ready}, 32'd1);
            check($sformatf("v%0d_resp_pulse", i), {31'd0, resp_valid}, 32'd0);
            check($sformatf("v%0d_rdata_held", i), resp_rdata, v.exp_rdata);
        end
    endtask

    // ------------------------------------------------------------------
    // Reset mid-transaction and a stray completion afterwards
    // ------------------------------------------------------------------
    task automatic run_reset_seq();
        int acc, cnt0;
        mem_auto   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        send(1'b0, 2'b11, 1'b0, 32'h0000_0500, 32'h0, acc);
        check("rst_seq_req1", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("rst_seq_wait1_noreq", {31'd0, mem_req}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_seq_ready", {31'd0, req_ready}, 32'd1);
        check("rst_seq_memreq", {31'd0, mem_req}, 32'd0);
        check("rst_seq_rdata", resp_rdata, 32'd0);
        cnt0 = n_resp;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        repeat (4) @(negedge clk);
        check("stray_no_resp", n_resp - cnt0, 32'd0);
        check("stray_ready", {31'd0, req_ready}, 32'd1);
        mst  = 0;
        wcnt = 0;
        mem_auto = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Randomized transactions against a byte-level reference memory
    // ------------------------------------------------------------------
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if (ref_mem.exists(a)) return ref_mem[a];
        w = dflt_word({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic run_random(input int count);
        logic        we, uns;
        logic [1:0]  size;
        logic [31:0] addr, wdata, a, val, rd;
        logic        er;
        int          nb, beats, k, acc, rc, pick;
        logic [31:0] ea [2];
        logic [3:0]  ebe [2];
        logic [31:0] ewd [2];
        mem_words.delete();
        ref_mem.delete();
        for (int t = 0; t < count; t++) begin
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 9);
            if (pick < 3)      begin size = 2'b00; nb = 1; end
            else if (pick < 6) begin size = 2'b01; nb = 2; end
            else if (pick < 9) begin size = 2'b11; nb = 4; end
            else               begin size = 2'b10; nb = 0; end
            if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            else                           addr = 32'h0000_1000 + 32'($urandom_range(0, 31));
            wdata     = $urandom;
            gnt_delay = $urandom_range(0, 2);
            rv_delay  = $urandom_range(0, 2);

            ea[0] = {addr[31:2], 2'b00};
            ea[1] = ea[0] + 32'd4;
            ebe[0] = 4'd0; ebe[1] = 4'd0;
            ewd[0] = 32'd0; ewd[1] = 32'd0;
            val = 32'd0;
            beats = 0;
            for (int i = 0; i < nb; i++) begin
                a = addr + 32'(i);
                k = ({a[31:2], 2'b00} == ea[0]) ? 0 : 1;
                if (k + 1 > beats) beats = k + 1;
                ebe[k][a[1:0]] = 1'b1;
                ewd[k][8*a[1:0] +: 8] = wdata[8*i +: 8];
                if (we) ref_mem[a] = wdata[8*i +: 8];
                else    val[8*i +: 8] = ref_byte(a);
            end
            if (!we && !uns && nb > 0 && nb < 4 && val[8*nb-1])
                val = val | ~((32'd1 << (8*nb)) - 32'd1);
            if (we || nb == 0) val = 32'd0;

            clear_beats();
            send(we, size, uns, addr, wdata, acc);
            wait_resp(rd, er, rc);
            check($sformatf("r%0d_rdata", t), rd, val);
            check($sformatf("r%0d_err", t), {31'd0, er}, {31'd0, (nb == 0)});
            check($sformatf("r%0d_latency", t), rc - acc,
                  (nb == 0) ? 32'd1 : 32'(1 + beats * (2 + gnt_delay + rv_delay)));
            check($sformatf("r%0d_beats", t), b_addr_q.size(), beats);
            for (int j = 0; j < 2; j++) begin
                if (j < beats && j < b_addr_q.size()) begin
                    check($sformatf("r%0d_b%0d_addr", t, j), b_addr_q[j], ea[j]);
                    check($sformatf("r%0d_b%0d_be", t, j), {28'd0, b_be_q[j]}, {28'd0, ebe[j]});
                    check($sformatf("r%0d_b%0d_we", t, j), {31'd0, b_we_q[j]}, {31'd0, we});
                    if (we)
                        check($sformatf("r%0d_b%0d_wdata", t, j),
                              b_wdata_q[j] & lane_mask(ebe[j]), ewd[j]);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);

        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_mem_be", {28'd0, mem_be}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        check("reset_mem_we", {31'd0, mem_we}, 32'd0);
        check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_resp_err", {31'd0, resp_err}, 32'd0);
        check("reset_resp_rdata", resp_rdata, 32'd0);
        rst = 1'b0;

        fill_table();
        run_directed();
        run_reset_seq();
        run_random(300);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
